// File: rtl/aes_round_seq.sv
// AES round-sequencing controller for 10/12/14-round operations.
// Drives step select and round-key index with stall, abort and done.
module aes_round_seq #(
    parameter int CW     = 4,
    parameter int NR_MAX = 14
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          en,
    input  logic          abort,
    output logic [2:0]    cs,
    output logic [CW-1:0] rnd,
    output logic          busy,
    output logic          done,
    output logic          last
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        ADD  = 3'b010,
        SUB  = 3'b011,
        SHI  = 3'b100,
        MIX  = 3'b101,
        FIN  = 3'b111
    } state_t;

    // Round counts are clamped so a small NR_MAX build stays consistent.
    localparam int NR_A = (10 > NR_MAX) ? NR_MAX : 10;
    localparam int NR_B = (12 > NR_MAX) ? NR_MAX : 12;
    localparam int NR_C = (14 > NR_MAX) ? NR_MAX : 14;

    state_t        r_cs;
    logic [CW-1:0] r_rnd;
    logic [CW-1:0] r_nr;
    logic [CW-1:0] w_nr_sel;
    logic          w_at_last;

    always_comb begin
        w_nr_sel = CW'(NR_A);
        unique case (mode)
            2'b00:   w_nr_sel = CW'(NR_A);
            2'b01:   w_nr_sel = CW'(NR_B);
            2'b10:   w_nr_sel = CW'(NR_C);
            default: w_nr_sel = CW'(NR_A);
        endcase
    end

    assign w_at_last = (r_rnd == r_nr);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_cs  <= IDLE;
            r_rnd <= '0;
            r_nr  <= CW'(NR_A);
        end else if (abort) begin
            r_cs  <= IDLE;
            r_rnd <= '0;
        end else if (en) begin
            case (r_cs)
                IDLE: begin
                    if (start) begin
                        r_nr  <= w_nr_sel;
                        r_rnd <= '0;
                        r_cs  <= LOAD;
                    end
                end
                LOAD: r_cs <= ADD;
                ADD: begin
                    if (w_at_last) begin
                        r_cs <= FIN;
                    end else begin
                        r_rnd <= r_rnd + CW'(1);
                        r_cs  <= SUB;
                    end
                end
                SUB: r_cs <= SHI;
                // Final round bypasses MixColumns.
                SHI: r_cs <= w_at_last ? ADD : MIX;
                MIX: r_cs <= ADD;
                FIN: begin
                    r_cs  <= IDLE;
                    r_rnd <= '0;
                end
                default: begin
                    r_cs  <= IDLE;
                    r_rnd <= '0;
                end
            endcase
        end
    end

    assign cs   = r_cs;
    assign rnd  = r_rnd;
    assign busy = (r_cs != IDLE);
    assign done = (r_cs == FIN);
    assign last = w_at_last;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed self-checking bench for aes_round_seq.
// Expected step/round sequence is derived from the round-count formula.
module tb_aes_round_seq;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LOAD = 3'b001;
    localparam logic [2:0] S_ADD  = 3'b010;
    localparam logic [2:0] S_SUB  = 3'b011;
    localparam logic [2:0] S_SHI  = 3'b100;
    localparam logic [2:0] S_MIX  = 3'b101;
    localparam logic [2:0] S_FIN  = 3'b111;

    logic       clk;
    logic       res;
    logic       start;
    logic [1:0] mode;
    logic       en;
    logic       abort;
    logic [2:0] cs;
    logic [3:0] rnd;
    logic       busy;
    logic       done;
    logic       last;

    int checks;
    int failures;

    aes_round_seq #(.CW(4), .NR_MAX(14)) dut (
        .clk   (clk),
        .res   (res),
        .start (start),
        .mode  (mode),
        .en    (en),
        .abort (abort),
        .cs    (cs),
        .rnd   (rnd),
        .busy  (busy),
        .done  (done),
        .last  (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cs"}, 32'(cs), 32'(S_IDLE));
        chk({tag, "_rnd"}, 32'(rnd), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // se/sn: stall sn edges while at step se; fs: stall edges in FIN;
    // hs: step at which start is re-pulsed with mode switched to 10.
    task automatic run_op(input logic [1:0] m, input int nr, input int se,
                          input int sn, input int fs, input int hs);
        logic [2:0] ecs;
        int         er;
        int         ph;
        int         k;
        mode  = m;
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        chk("load_cs", 32'(cs), 32'(S_LOAD));
        chk("load_busy", 32'(busy), 1);
        chk("load_rnd", 32'(rnd), 0);
        for (int e = 1; e <= 4 * nr + 1; e++) begin
            tick();
            start = 1'b0;
            if (e == 4 * nr + 1) begin
                ecs = S_FIN;
                er  = nr;
            end else if (e == 4 * nr) begin
                ecs = S_ADD;
                er  = nr;
            end else begin
                ph = (e - 1) % 4;
                k  = (e - 1) / 4;
                case (ph)
                    0:       begin ecs = S_ADD; er = k;     end
                    1:       begin ecs = S_SUB; er = k + 1; end
                    2:       begin ecs = S_SHI; er = k + 1; end
                    default: begin ecs = S_MIX; er = k + 1; end
                endcase
            end
            chk("seq_cs", 32'(cs), 32'(ecs));
            chk("seq_rnd", 32'(rnd), 32'(er));
            chk("seq_last", 32'(last), 32'(er == nr));
            chk("seq_done", 32'(done), 32'(e == 4 * nr + 1));
            chk("seq_busy", 32'(busy), 1);
            if (e == se) begin
                en = 1'b0;
                for (int s = 0; s < sn; s++) begin
                    tick();
                    chk("stall_cs", 32'(cs), 32'(ecs));
                    chk("stall_rnd", 32'(rnd), 32'(er));
                end
                en = 1'b1;
            end
            if (e == hs) begin
                start = 1'b1;
                mode  = 2'b10;
            end
        end
        if (fs > 0) begin
            en = 1'b0;
            for (int s = 0; s < fs; s++) begin
                tick();
                chk("finhold_cs", 32'(cs), 32'(S_FIN));
                chk("finhold_done", 32'(done), 1);
            end
            en = 1'b1;
        end
        tick();
        chk_idle("post_fin");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        res      = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        en       = 1'b1;
        abort    = 1'b0;
        #12;
        chk_idle("reset");
        chk("reset_last", 32'(last), 0);
        @(negedge clk);
        res = 1'b1;
        tick();
        chk_idle("idle_nostart");

        run_op(2'b00, 10, 0, 0, 0, 0);
        run_op(2'b01, 12, 0, 0, 0, 0);
        run_op(2'b10, 14, 0, 0, 0, 0);
        run_op(2'b11, 10, 0, 0, 0, 0);
        run_op(2'b00, 10, 15, 3, 2, 0);
        run_op(2'b00, 10, 0, 0, 0, 9);

        // Abort during MIX of round 5.
        mode  = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 20; e++) tick();
        chk("ab_pre_cs", 32'(cs), 32'(S_MIX));
        chk("ab_pre_rnd", 32'(rnd), 5);
        abort = 1'b1;
        en    = 1'b0;
        tick();
        abort = 1'b0;
        en    = 1'b1;
        chk_idle("abort");
        tick();
        chk_idle("abort_after");

        // Abort beats start in IDLE.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk_idle("abort_start");

        // Asynchronous reset during SUB of round 7.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 26; e++) tick();
        chk("rst_pre_cs", 32'(cs), 32'(S_SUB));
        chk("rst_pre_rnd", 32'(rnd), 7);
        chk("rst_pre_busy", 32'(busy), 1);
        #2;
        res = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_last", 32'(last), 0);
        tick();
        res = 1'b1;
        tick();
        chk_idle("rst_release");

        run_op(2'b01, 12, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
